// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD timing generator: sync, back porch, active and front porch
// phases per line and per frame, with registered sync/enable/coordinate/strobe outputs.
module vga_timing_gen #(
  parameter int H_SW   = 120,
  parameter int H_BP   = 64,
  parameter int H_EN   = 800,
  parameter int H_FP   = 56,
  parameter int V_SW   = 6,
  parameter int V_BP   = 23,
  parameter int V_EN   = 600,
  parameter int V_FP   = 37,
  parameter int HS_POL = 1,
  parameter int VS_POL = 1,
  parameter int CNT_W  = 12
) (
  input  logic             pclk,
  input  logic             rstn,
  input  logic             ce,
  output logic             hs,
  output logic             vs,
  output logic             hen,
  output logic             ven,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SW + H_BP + H_EN + H_FP;
  localparam int V_TOTAL = V_SW + V_BP + V_EN + V_FP;
  localparam int H_A0    = H_SW + H_BP;
  localparam int V_A0    = V_SW + V_BP;

  localparam logic [1:0] PH_SW = 2'd0;
  localparam logic [1:0] PH_BP = 2'd1;
  localparam logic [1:0] PH_EN = 2'd2;
  localparam logic [1:0] PH_FP = 2'd3;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BP0  = CNT_W'(H_SW);
  localparam logic [CNT_W-1:0] H_EN0  = CNT_W'(H_A0);
  localparam logic [CNT_W-1:0] H_FP0  = CNT_W'(H_A0 + H_EN);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_BP0  = CNT_W'(V_SW);
  localparam logic [CNT_W-1:0] V_EN0  = CNT_W'(V_A0);
  localparam logic [CNT_W-1:0] V_FP0  = CNT_W'(V_A0 + V_EN);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  generate
    if (H_SW < 1 || H_BP < 1 || H_EN < 1 || H_FP < 1 ||
        V_SW < 1 || V_BP < 1 || V_EN < 1 || V_FP < 1 ||
        64'(H_TOTAL) > (64'd1 << CNT_W) || 64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_params
      $fatal(1, "vga_timing_gen: illegal timing parameter set");
    end
  endgenerate

  // Counters step by one, so a phase only changes when the count lands on a boundary.
  function automatic logic [1:0] next_phase(input logic [CNT_W-1:0] cnt,
                                            input logic [1:0]       ph,
                                            input logic [CNT_W-1:0] bp0,
                                            input logic [CNT_W-1:0] en0,
                                            input logic [CNT_W-1:0] fp0);
    logic [1:0] r;
    if (cnt == '0)       r = PH_SW;
    else if (cnt == bp0) r = PH_BP;
    else if (cnt == en0) r = PH_EN;
    else if (cnt == fp0) r = PH_FP;
    else                 r = ph;
    return r;
  endfunction

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]       h_ph_q, h_ph_d, v_ph_q, v_ph_d;
  logic             hs_q, hs_d, vs_q, vs_d, hen_q, hen_d, ven_q, ven_d, de_q, de_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic             h_wrap_s;

  // Next counter/phase state, and outputs decoded from that next state.
  always_comb begin
    h_wrap_s = (h_cnt_q == H_LAST);
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    h_ph_d   = h_ph_q;
    v_ph_d   = v_ph_q;
    if (ce) begin
      h_cnt_d = h_wrap_s ? '0 : h_cnt_q + ONE;
      h_ph_d  = next_phase(h_cnt_d, h_ph_q, H_BP0, H_EN0, H_FP0);
      if (h_wrap_s) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
        v_ph_d  = next_phase(v_cnt_d, v_ph_q, V_BP0, V_EN0, V_FP0);
      end else begin
        v_cnt_d = v_cnt_q;
        v_ph_d  = v_ph_q;
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      h_ph_d  = h_ph_q;
      v_ph_d  = v_ph_q;
    end
    hs_d  = (h_ph_d == PH_SW) ? HS_ON : ~HS_ON;
    vs_d  = (v_ph_d == PH_SW) ? VS_ON : ~VS_ON;
    hen_d = (h_ph_d == PH_EN);
    ven_d = (v_ph_d == PH_EN);
    de_d  = hen_d & ven_d;
    x_d   = hen_d ? (h_cnt_d - H_EN0) : '0;
    y_d   = ven_d ? (v_cnt_d - V_EN0) : '0;
    ls_d  = ce & (h_cnt_d == '0);
    fs_d  = ls_d & (v_cnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_ph_q  <= PH_SW;
      v_ph_q  <= PH_SW;
      hs_q    <= HS_ON;
      vs_q    <= VS_ON;
      hen_q   <= 1'b0;
      ven_q   <= 1'b0;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_ph_q  <= h_ph_d;
      v_ph_q  <= v_ph_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      hen_q   <= hen_d;
      ven_q   <= ven_d;
      de_q    <= de_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign hen         = hen_q;
  assign ven         = ven_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
